// File: rtl/bnn_threshold_packer.sv
// -----------------------------------------------------------------------------
// bnn_threshold_packer
//
// Purpose:
//   Consumes one accumulated popcount per output neuron, binarises it against a
//   per-neuron threshold (folded batch-norm scale/shift followed by sign), packs
//   the resulting activation bits LSB-first into WORD_SIZE-bit words and emits
//   each word with its destination address toward the activation SRAM of the
//   next layer.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   thr_wr_en    in   threshold table write strobe (honoured only while idle)
//   thr_wr_addr  in   threshold table index
//   thr_wr_data  in   threshold value (unsigned, ACC_W bits)
//   thr_wr_inv   in   polarity stored with the threshold (1 = negative BN scale)
//   start        in   begin a run (sampled in IDLE only)
//   num_neurons  in   neurons in this run, 0..MAX_NEURONS, latched at start
//   out_base     in   first output word address, latched at start
//   in_valid     in   popcount valid
//   in_ready     out  block accepts a popcount
//   in_popcount  in   accumulated popcount for the current neuron
//   out_valid    out  packed word valid
//   out_ready    in   sink accepts the word
//   out_data     out  packed activation bits
//   out_addr     out  destination word address (wraps modulo 2^ADDR_W)
//   out_last     out  final word of the run, qualified by out_valid
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module bnn_threshold_packer #(
   parameter int WORD_SIZE   = 64,
   parameter int ACC_W       = 32,
   parameter int MAX_NEURONS = 256,
   parameter int ADDR_W      = 6
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           thr_wr_en,
   input  logic [$clog2(MAX_NEURONS)-1:0] thr_wr_addr,
   input  logic [ACC_W-1:0]               thr_wr_data,
   input  logic                           thr_wr_inv,
   input  logic                           start,
   input  logic [$clog2(MAX_NEURONS):0]   num_neurons,
   input  logic [ADDR_W-1:0]              out_base,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ACC_W-1:0]               in_popcount,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WORD_SIZE-1:0]           out_data,
   output logic [ADDR_W-1:0]              out_addr,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
);

   localparam int IDX_W = $clog2(MAX_NEURONS);
   localparam int CNT_W = IDX_W + 1;
   localparam int BIT_W = $clog2(WORD_SIZE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_EMIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   // Threshold table: {polarity, threshold}. Deliberately not reset so that
   // thresholds survive a reset that aborts a run.
   logic [ACC_W:0]        r_thr_mem [MAX_NEURONS];

   logic [CNT_W-1:0]      r_count;
   logic [ADDR_W-1:0]     r_base;
   logic [CNT_W-1:0]      r_neuron_idx;
   logic [BIT_W-1:0]      r_bit_pos;
   logic [ADDR_W-1:0]     r_word_idx;
   logic [WORD_SIZE-1:0]  r_pack;
   logic [WORD_SIZE-1:0]  r_out_data;
   logic                  r_last;

   logic                  w_thr_we;
   logic [ACC_W:0]        w_thr_entry;
   logic [ACC_W-1:0]      w_thr;
   logic                  w_inv;
   logic                  w_bit;
   logic                  w_hs;
   logic                  w_last_neuron;
   logic                  w_word_full;
   logic                  w_word_end;
   logic [WORD_SIZE-1:0]  w_pack_upd;
   logic [CNT_W-1:0]      w_count_clamped;

   // ---------------------------------------------------------------------------
   // Threshold table write / read
   // ---------------------------------------------------------------------------
   // Writes are only honoured while idle so a run never sees its thresholds
   // change underneath it.
   assign w_thr_we = thr_wr_en && (r_state == S_IDLE);

   always_ff @(posedge clk) begin
      if (w_thr_we) begin
         r_thr_mem[thr_wr_addr] <= {thr_wr_inv, thr_wr_data};
      end
   end

   assign w_thr_entry = r_thr_mem[r_neuron_idx[IDX_W-1:0]];
   assign w_thr       = w_thr_entry[ACC_W-1:0];
   assign w_inv       = w_thr_entry[ACC_W];

   // Negative BN scale flips the inequality; equality therefore maps to 1 for
   // normal polarity and 0 for inverted polarity.
   assign w_bit = w_inv ? (in_popcount < w_thr) : (in_popcount >= w_thr);

   // ---------------------------------------------------------------------------
   // Handshake and word-boundary decode
   // ---------------------------------------------------------------------------
   assign w_hs          = in_valid && (r_state == S_ACCEPT);
   assign w_last_neuron = (r_neuron_idx == (r_count - CNT_W'(1)));
   assign w_word_full   = (r_bit_pos == BIT_W'(WORD_SIZE - 1));
   assign w_word_end    = w_word_full || w_last_neuron;

   // The pack register is cleared at every word boundary, so OR-ing the new bit
   // in leaves every position above bit_pos at zero (zero-padded last word).
   assign w_pack_upd = r_pack | ({{(WORD_SIZE-1){1'b0}}, w_bit} << r_bit_pos);

   // Protect the table index against an out-of-range neuron count.
   assign w_count_clamped = (num_neurons > CNT_W'(MAX_NEURONS)) ?
                            CNT_W'(MAX_NEURONS) : num_neurons;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and control outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_nxt = (num_neurons == '0) ? S_DONE : S_ACCEPT;
            end
         end

         S_ACCEPT: begin
            in_ready = 1'b1;
            if (w_hs && w_word_end) begin
               w_state_nxt = S_EMIT;
            end
         end

         S_EMIT: begin
            out_valid = 1'b1;
            out_last  = r_last;
            if (out_ready) begin
               w_state_nxt = r_last ? S_DONE : S_ACCEPT;
            end
         end

         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Run counters, pack register and output word register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count      <= '0;
         r_base       <= '0;
         r_neuron_idx <= '0;
         r_bit_pos    <= '0;
         r_word_idx   <= '0;
         r_pack       <= '0;
         r_out_data   <= '0;
         r_last       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (num_neurons != '0)) begin
                  r_count      <= w_count_clamped;
                  r_base       <= out_base;
                  r_neuron_idx <= '0;
                  r_bit_pos    <= '0;
                  r_word_idx   <= '0;
                  r_pack       <= '0;
               end
            end

            S_ACCEPT: begin
               if (w_hs) begin
                  r_pack       <= w_pack_upd;
                  r_neuron_idx <= r_neuron_idx + CNT_W'(1);
                  r_bit_pos    <= r_bit_pos + BIT_W'(1);
                  if (w_word_end) begin
                     // Snapshot into a separate register so out_data stays
                     // stable for as long as the sink back-pressures.
                     r_out_data <= w_pack_upd;
                     r_last     <= w_last_neuron;
                  end
               end
            end

            S_EMIT: begin
               if (out_ready) begin
                  r_word_idx <= r_word_idx + ADDR_W'(1);
                  r_pack     <= '0;
                  r_bit_pos  <= '0;
               end
            end

            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output datapath
   // ---------------------------------------------------------------------------
   // The ADDR_W-bit sum wraps naturally from 2^ADDR_W-1 back to 0.
   assign out_addr = r_base + r_word_idx;
   assign out_data = r_out_data;

endmodule
